read_sched_core: RTL and testbench

//   Read-side scheduler for one SRAM output port. Picks which of NUM_QUEUES priority

---
 rtl/read_sched_core_pkg.sv | 14 +
 rtl/read_sched_core_if.sv | 26 ++
 rtl/read_sched_core_wrr_picker.sv | 69 ++++++
 rtl/read_sched_core.sv | 107 ++++++++++
 tb/tb_read_sched_core.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/read_sched_core_pkg.sv
// Shared definitions for the read-side scheduler: FSM encodings and default sizing.
package read_sched_core_pkg;

    localparam int DEF_NUM_QUEUES = 8;
    localparam int DEF_WEIGHT_W   = 4;
    localparam int PRIO_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

endpackage

// File: rtl/read_sched_core_if.sv
// Scheduler <-> read-engine bundle. The master side is the scheduler, the slave side
// is the read path and queue manager that feed it.
interface read_sched_core_if #(
    parameter int NUM_QUEUES = 8,
    parameter int WEIGHT_W   = 4,
    parameter int SEL_W      = 3
);
    logic                         sp0_wrr1;
    logic                         port_ready;
    logic [NUM_QUEUES-1:0]        q_nonempty;
    logic [NUM_QUEUES*WEIGHT_W-1:0] weights;
    logic                         rd_eop;
    logic [SEL_W-1:0]             select;
    logic                         transfering;
    logic                         rd_start;

    modport master (
        input  sp0_wrr1, port_ready, q_nonempty, weights, rd_eop,
        output select, transfering, rd_start
    );

    modport slave (
        output sp0_wrr1, port_ready, q_nonempty, weights, rd_eop,
        input  select, transfering, rd_start
    );
endinterface

// File: rtl/read_sched_core_wrr_picker.sv
// Weighted round-robin picker: owns per-queue credits and the rotating pointer.
// Only instantiated when READ_SCHED_WRR_EN is defined.
module wrr_picker #(
    parameter int NUM_QUEUES = 8,
    parameter int WEIGHT_W   = 4,
    parameter int SEL_W      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_QUEUES-1:0]          q_nonempty,
    input  logic [NUM_QUEUES*WEIGHT_W-1:0] weights,
    input  logic                           advance,
    output logic [SEL_W-1:0]               winner
);

    logic [WEIGHT_W-1:0] credit [NUM_QUEUES];
    logic [WEIGHT_W-1:0] reload [NUM_QUEUES];
    logic [SEL_W-1:0]    rr_ptr;
    logic [NUM_QUEUES-1:0] eligible;
    logic [NUM_QUEUES-1:0] cand;
    logic                need_reload;
    logic                found;
    int                  idx;

    // When no requesting queue has credit left, the scan runs against freshly
    // reloaded credits, which are all at least 1, so every nonempty queue qualifies.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            reload[i]   = (weights[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                          WEIGHT_W'(1) : weights[i*WEIGHT_W +: WEIGHT_W];
            eligible[i] = q_nonempty[i] && (credit[i] != '0);
        end
        need_reload = ~|eligible;
        cand        = need_reload ? q_nonempty : eligible;
        winner      = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_QUEUES) begin
                idx = idx - NUM_QUEUES;
            end
            if (!found && cand[idx]) begin
                winner = SEL_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                credit[i] <= '0;
            end
            rr_ptr <= '0;
        end else if (advance) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (winner == SEL_W'(i)) begin
                    credit[i] <= (need_reload ? reload[i] : credit[i]) - WEIGHT_W'(1);
                end else begin
                    credit[i] <= need_reload ? reload[i] : credit[i];
                end
            end
            rr_ptr <= (int'(winner) == NUM_QUEUES - 1) ? '0 : winner + SEL_W'(1);
        end
    end

endmodule

// File: rtl/read_sched_core.sv
// Read-side packet scheduler for one SRAM output port: SP always, WRR when
// READ_SCHED_WRR_EN is defined. One grant covers one whole packet.
module read_sched_core
    import read_sched_core_pkg::*;
#(
    parameter int NUM_QUEUES = DEF_NUM_QUEUES,
    parameter int WEIGHT_W   = DEF_WEIGHT_W,
    parameter int SEL_W      = PRIO_W
) (
    input logic               clk,
    input logic               rst,
    read_sched_core_if.master bus
);

    state_t           state;
    logic [SEL_W-1:0] select_q;
    logic             transfering_q;
    logic             rd_start_q;
    logic [SEL_W-1:0] sp_winner;
    logic [SEL_W-1:0] winner;
    logic             any_req;

    assign bus.select      = select_q;
    assign bus.transfering = transfering_q;
    assign bus.rd_start    = rd_start_q;
    assign any_req         = |bus.q_nonempty;

    // Highest index wins, so later loop iterations override earlier ones.
    always_comb begin
        sp_winner = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (bus.q_nonempty[i]) begin
                sp_winner = SEL_W'(i);
            end
        end
    end

`ifdef READ_SCHED_WRR_EN
    logic             advance;
    logic [SEL_W-1:0] wrr_winner;

    assign advance = (state == ST_ARB) && any_req && bus.sp0_wrr1;
    assign winner  = bus.sp0_wrr1 ? wrr_winner : sp_winner;

    wrr_picker #(
        .NUM_QUEUES (NUM_QUEUES),
        .WEIGHT_W   (WEIGHT_W),
        .SEL_W      (SEL_W)
    ) u_wrr_picker (
        .clk        (clk),
        .rst        (rst),
        .q_nonempty (bus.q_nonempty),
        .weights    (bus.weights),
        .advance    (advance),
        .winner     (wrr_winner)
    );
`else
    logic unused_wrr_cfg;

    assign unused_wrr_cfg = ^{bus.sp0_wrr1, bus.weights};
    assign winner         = sp_winner;
`endif

    // Queue state is re-checked in ARB because a packet may have been drained
    // elsewhere between the IDLE decision and the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            select_q      <= '0;
            transfering_q <= 1'b0;
            rd_start_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rd_start_q <= 1'b0;
                    if (bus.port_ready && any_req) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (any_req) begin
                        select_q      <= winner;
                        transfering_q <= 1'b1;
                        rd_start_q    <= 1'b1;
                        state         <= ST_XFER;
                    end else begin
                        rd_start_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    rd_start_q <= 1'b0;
                    if (bus.rd_eop) begin
                        transfering_q <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    rd_start_q    <= 1'b0;
                    transfering_q <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_sched_core.sv
// Bench for read_sched_core: table-driven grants with a select scoreboard plus
// hand-written reset, hold and gating sequences. WRR checks need READ_SCHED_WRR_EN.
module tb_read_sched_core;

    typedef struct {
        logic [7:0]  q;
        logic        mode;
        logic [31:0] w;
        logic [2:0]  sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    logic [2:0] exp_q [$];
    logic [2:0] mon_exp;
    vec_t sp_vecs [6];

    always #5 clk = ~clk;

    read_sched_core_if #(.NUM_QUEUES(8), .WEIGHT_W(4), .SEL_W(3)) bus ();

    read_sched_core #(.NUM_QUEUES(8), .WEIGHT_W(4), .SEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Every rd_start must match the oldest outstanding expected grant.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.rd_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_rd_start", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("grant_select", 32'(bus.select), 32'(mon_exp));
            end
        end
    end

    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.rd_start !== 1'b1 && cycles < 12);
        check_output("grant_seen", 32'(bus.rd_start), 32'd1);
        if (bus.rd_start !== 1'b1 && exp_q.size() != 0) begin
            void'(exp_q.pop_back());
        end
    endtask

    task automatic finish_packet();
        bus.rd_eop     = 1'b1;
        bus.q_nonempty = 8'h00;
        @(negedge clk);
        bus.rd_eop = 1'b0;
        check_output("eop_transfering", 32'(bus.transfering), 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        int lat;
        bus.q_nonempty = v.q;
        bus.sp0_wrr1   = v.mode;
        bus.weights    = v.w;
        bus.port_ready = 1'b1;
        exp_q.push_back(v.sel);
        wait_grant(lat);
        check_output("grant_latency", 32'(lat), 32'd2);
        check_output("grant_transfering", 32'(bus.transfering), 32'd1);
        @(negedge clk);
        check_output("pulse_width", 32'(bus.rd_start), 32'd0);
        finish_packet();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int pulses;
        vec_t v;

        sp_vecs[0] = '{q: 8'b0010_0110, mode: 1'b0, w: 32'h0, sel: 3'd5};
        sp_vecs[1] = '{q: 8'b0000_0110, mode: 1'b0, w: 32'h0, sel: 3'd2};
        sp_vecs[2] = '{q: 8'b1000_0001, mode: 1'b0, w: 32'h0, sel: 3'd7};
        sp_vecs[3] = '{q: 8'b0000_0001, mode: 1'b0, w: 32'h0, sel: 3'd0};
        sp_vecs[4] = '{q: 8'b0100_1000, mode: 1'b0, w: 32'h0, sel: 3'd6};
        sp_vecs[5] = '{q: 8'b0001_1010, mode: 1'b0, w: 32'h0, sel: 3'd4};

        rst            = 1'b1;
        bus.sp0_wrr1   = 1'b0;
        bus.port_ready = 1'b0;
        bus.q_nonempty = 8'h00;
        bus.weights    = 32'h0;
        bus.rd_eop     = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_select", 32'(bus.select), 32'd0);
        check_output("reset_transfering", 32'(bus.transfering), 32'd0);
        check_output("reset_rd_start", 32'(bus.rd_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] strict priority table");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(sp_vecs[i]);
        end

        $display("[TB] strict priority hold during transfer");
        bus.q_nonempty = 8'b0000_0110;
        bus.port_ready = 1'b1;
        exp_q.push_back(3'd2);
        wait_grant(lat);
        bus.q_nonempty = 8'b1000_0110;
        bus.sp0_wrr1   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("hold_select", 32'(bus.select), 32'd2);
            check_output("hold_transfering", 32'(bus.transfering), 32'd1);
        end
        bus.sp0_wrr1 = 1'b0;
        bus.rd_eop   = 1'b1;
        exp_q.push_back(3'd7);
        @(negedge clk);
        bus.rd_eop = 1'b0;
        check_output("hold_eop_transfering", 32'(bus.transfering), 32'd0);
        wait_grant(lat);
        check_output("eop_to_start_gap", 32'(lat), 32'd2);
        finish_packet();

        $display("[TB] reset in the middle of a transfer");
        v = '{q: 8'b0010_0000, mode: 1'b0, w: 32'h0, sel: 3'd5};
        bus.q_nonempty = v.q;
        exp_q.push_back(v.sel);
        wait_grant(lat);
        @(negedge clk);
        check_output("pre_reset_select", 32'(bus.select), 32'd5);
        rst            = 1'b1;
        bus.q_nonempty = 8'h00;
        @(negedge clk);
        check_output("midreset_transfering", 32'(bus.transfering), 32'd0);
        check_output("midreset_select", 32'(bus.select), 32'd0);
        check_output("midreset_rd_start", 32'(bus.rd_start), 32'd0);
        rst        = 1'b0;
        bus.rd_eop = 1'b1;
        @(negedge clk);
        bus.rd_eop = 1'b0;
        check_output("stray_eop_transfering", 32'(bus.transfering), 32'd0);
        check_output("stray_eop_select", 32'(bus.select), 32'd0);

        $display("[TB] gating by port_ready and empty queues in ARB");
        bus.port_ready = 1'b0;
        bus.q_nonempty = 8'hFF;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rd_start === 1'b1) pulses++;
        end
        check_output("gated_pulses", 32'(pulses), 32'd0);
        check_output("gated_transfering", 32'(bus.transfering), 32'd0);
        bus.q_nonempty = 8'h00;
        @(negedge clk);
        bus.port_ready = 1'b1;
        bus.q_nonempty = 8'h10;
        @(negedge clk);
        bus.q_nonempty = 8'h00;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rd_start === 1'b1) pulses++;
        end
        check_output("arb_drop_pulses", 32'(pulses), 32'd0);
        check_output("arb_drop_transfering", 32'(bus.transfering), 32'd0);
        apply_stimulus('{q: 8'h10, mode: 1'b0, w: 32'h0, sel: 3'd4});

`ifdef READ_SCHED_WRR_EN
        $display("[TB] weighted round robin, all queues busy");
        do_reset();
        begin
            logic [2:0] seq [10];
            seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
            for (int i = 0; i < 10; i++) begin
                apply_stimulus('{q: 8'hFF, mode: 1'b1, w: 32'h0000_0012, sel: seq[i]});
            end
        end

        $display("[TB] weighted round robin skipping idle queues");
        do_reset();
        begin
            logic [2:0] seq2 [4];
            seq2 = '{3'd3, 3'd6, 3'd3, 3'd6};
            for (int i = 0; i < 4; i++) begin
                apply_stimulus('{q: 8'b0100_1000, mode: 1'b1, w: 32'h1111_1111, sel: seq2[i]});
            end
        end

        $display("[TB] strict priority leaves WRR state alone");
        apply_stimulus('{q: 8'b0100_1000, mode: 1'b0, w: 32'h1111_1111, sel: 3'd6});
        apply_stimulus('{q: 8'b0100_1000, mode: 1'b1, w: 32'h1111_1111, sel: 3'd3});
`else
        $display("[TB] WRR disabled: mode and weights ignored");
        apply_stimulus('{q: 8'hFF, mode: 1'b1, w: 32'h0000_0012, sel: 3'd7});
        apply_stimulus('{q: 8'b0100_1000, mode: 1'b1, w: 32'h1111_1111, sel: 3'd6});
        apply_stimulus('{q: 8'b0000_0011, mode: 1'b1, w: 32'hFFFF_FFFF, sel: 3'd1});
`endif

        repeat (3) @(negedge clk);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
